spi_ram_burst: RTL and testbench

//  Parametrised single-port RAM behind the SPI slave; decodes {cmd[1:0], data} frames on rx_valid.

---
 rtl/spi_ram_pkg.sv | 13 +
 rtl/spi_ram_mem.sv | 57 +++++
 rtl/spi_ram_burst.sv | 103 ++++++++++
 tb/tb_spi_ram_burst.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - frame command encoding shared by the SPI RAM blocks
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - storage array with write port and RD_LAT-stage pipelined read
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic [RD_LAT-1:0] pipe_v;

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Read pipeline: each stage only loads when its upstream stage is valid, so the
    // last stage (dout) holds its value between reads and changes only with tx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_en;
            if (rd_en) begin
                pipe_d[0] <= mem[rd_addr[IDX_W-1:0]];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign dout     = pipe_d[RD_LAT-1];
    assign tx_valid = pipe_v[RD_LAT-1];

endmodule

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - SPI frame decoder with burst pointers in front of a parametrised RAM
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int RD_LAT    = 1,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              addr_err
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_in;
    logic              addr_ok;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic              do_wr, do_rd;

    assign cmd     = cmd_e'(din[DATA_W+CMD_W-1:DATA_W]);
    assign payload = din[DATA_W-1:0];
    assign addr_in = payload[ADDR_W-1:0];
    // An address is only accepted if no bits above the pointer width are set and it lies inside the array.
    assign addr_ok = ((payload >> ADDR_W) == '0) && ({1'b0, addr_in} < DEPTH_L);

    assign wr_ptr_inc = (wr_ptr == LAST_A) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == LAST_A) ? '0 : rd_ptr + 1'b1;

    assign do_wr = rx_valid && (cmd == CMD_WR_DATA);
    assign do_rd = rx_valid && (cmd == CMD_RD_DATA);

    // Pointer registers and the one-cycle address error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        if (addr_ok) wr_ptr <= addr_in;
                        else         addr_err <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (AUTO_INC != 0) wr_ptr <= wr_ptr_inc;
                    end
                    CMD_RD_ADDR: begin
                        if (addr_ok) rd_ptr <= addr_in;
                        else         addr_err <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        if (AUTO_INC != 0) rd_ptr <= rd_ptr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .RD_LAT    (RD_LAT)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (do_wr),
        .wr_addr  (wr_ptr),
        .wr_data  (payload),
        .rd_en    (do_rd),
        .rd_addr  (rd_ptr),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

`ifdef SIM
    a_wr_addr: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid && cmd == CMD_WR_ADDR && addr_ok |=> wr_ptr == $past(addr_in));
    a_rd_addr: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid && cmd == CMD_RD_ADDR && addr_ok |=> rd_ptr == $past(addr_in));
    a_wr_inc: assert property (@(posedge clk) disable iff (!rst_n)
        (AUTO_INC != 0) && do_wr |=> wr_ptr == ADDR_W'((32'($past(wr_ptr)) + 1) % MEM_DEPTH));
    a_rd_inc: assert property (@(posedge clk) disable iff (!rst_n)
        (AUTO_INC != 0) && do_rd |=> rd_ptr == ADDR_W'((32'($past(rd_ptr)) + 1) % MEM_DEPTH));
    a_rd_lat: assert property (@(posedge clk) disable iff (!rst_n)
        do_rd |-> ##RD_LAT tx_valid);
`endif

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb/tb_spi_ram_burst.sv - scoreboard bench for spi_ram_burst across several parameter sets
module tb_spi_ram_burst;

    typedef struct packed {
        logic [1:0]  k;
        logic        kind;
        logic [15:0] c;
        logic [7:0]  d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  din;
    logic        rxv;
    int          sel;
    logic [3:0]  rv;
    logic [7:0]  dout [4];
    logic [3:0]  tx;
    logic [3:0]  err;
    logic [15:0] cyc = '0;

    ev_t expq[$];
    ev_t obsq[$];
    ev_t e, o;
    int  checks = 0;
    int  failures = 0;

    int         depth [4] = '{256, 16, 200, 256};
    int         lat   [4] = '{1, 1, 2, 1};
    int         inc   [4] = '{1, 1, 1, 0};
    logic [7:0] mm    [4][256];
    int         wp    [4];
    int         rp    [4];

    always #5 clk = ~clk;

    assign rv = rxv ? (4'b0001 << sel) : 4'b0000;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .RD_LAT(1), .AUTO_INC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rv[0]),
        .dout(dout[0]), .tx_valid(tx[0]), .addr_err(err[0]));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(4), .MEM_DEPTH(16), .RD_LAT(1), .AUTO_INC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rv[1]),
        .dout(dout[1]), .tx_valid(tx[1]), .addr_err(err[1]));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .RD_LAT(2), .AUTO_INC(1)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rv[2]),
        .dout(dout[2]), .tx_valid(tx[2]), .addr_err(err[2]));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .RD_LAT(1), .AUTO_INC(0)) u3 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rv[3]),
        .dout(dout[3]), .tx_valid(tx[3]), .addr_err(err[3]));

    always @(posedge clk) cyc <= cyc + 16'd1;

    // Record every output event with the cycle it appeared in.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (tx[k] === 1'b1)  obsq.push_back(ev_t'({2'(k), 1'b0, cyc, dout[k]}));
            if (err[k] === 1'b1) obsq.push_back(ev_t'({2'(k), 1'b1, cyc, 8'h00}));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            wp[k] = 0;
            rp[k] = 0;
        end
    endtask

    // Drive one frame to DUT k and push the outputs it must produce.
    task automatic send(input int k, input logic [1:0] c, input logic [7:0] p);
        sel = k;
        din = {c, p};
        rxv = 1'b1;
        @(posedge clk);
        #1;
        rxv = 1'b0;
        case (c)
            2'b00: if (p < depth[k]) wp[k] = p;
                   else expq.push_back(ev_t'({2'(k), 1'b1, cyc, 8'h00}));
            2'b01: begin
                mm[k][wp[k]] = p;
                if (inc[k] != 0) wp[k] = (wp[k] + 1) % depth[k];
            end
            2'b10: if (p < depth[k]) rp[k] = p;
                   else expq.push_back(ev_t'({2'(k), 1'b1, cyc, 8'h00}));
            default: begin
                expq.push_back(ev_t'({2'(k), 1'b0, cyc + 16'(lat[k] - 1), mm[k][rp[k]]}));
                if (inc[k] != 0) rp[k] = (rp[k] + 1) % depth[k];
            end
        endcase
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dout[k] !== 8'h00) begin failures++; $display("FAIL reset_dout%0d got=%h exp=00", k, dout[k]); end
            checks++;
            if (tx[k] !== 1'b0) begin failures++; $display("FAIL reset_tx%0d got=%b exp=0", k, tx[k]); end
            checks++;
            if (err[k] !== 1'b0) begin failures++; $display("FAIL reset_err%0d got=%b exp=0", k, err[k]); end
        end
        obsq.delete();
    endtask

    task automatic test_defaults();
        send(0, 2'b00, 8'h10);
        send(0, 2'b01, 8'hA5);
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        idle(4);
        checks++;
        if (dout[0] !== 8'hA5) begin failures++; $display("FAIL defaults_hold got=%h exp=a5", dout[0]); end
        checks++;
        if (obsq.size() != expq.size()) begin failures++; $display("FAIL defaults_count got=%0d exp=%0d", obsq.size(), expq.size()); end
        while (expq.size() != 0 && obsq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL defaults_event got=%h exp=%h", o, e); end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_burst();
        send(0, 2'b00, 8'h20);
        send(0, 2'b01, 8'h01);
        send(0, 2'b01, 8'h02);
        send(0, 2'b01, 8'h03);
        send(0, 2'b01, 8'h44);
        send(0, 2'b10, 8'h20);
        for (int i = 0; i < 4; i++) send(0, 2'b11, 8'h00);
        idle(4);
        checks++;
        if (obsq.size() != expq.size()) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", obsq.size(), expq.size()); end
        while (expq.size() != 0 && obsq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL burst_event got=%h exp=%h", o, e); end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_wrap();
        send(1, 2'b00, 8'd15);
        send(1, 2'b01, 8'h11);
        send(1, 2'b01, 8'h22);
        send(1, 2'b01, 8'h33);
        send(1, 2'b00, 8'd16);
        send(1, 2'b10, 8'd15);
        for (int i = 0; i < 3; i++) send(1, 2'b11, 8'h00);
        idle(4);
        checks++;
        if (obsq.size() != expq.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", obsq.size(), expq.size()); end
        while (expq.size() != 0 && obsq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL wrap_event got=%h exp=%h", o, e); end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_range();
        send(2, 2'b00, 8'd5);
        send(2, 2'b01, 8'h5A);
        send(2, 2'b00, 8'd199);
        send(2, 2'b01, 8'h77);
        send(2, 2'b10, 8'd5);
        send(2, 2'b10, 8'hC8);
        send(2, 2'b00, 8'hFF);
        send(2, 2'b11, 8'h00);
        send(2, 2'b10, 8'd199);
        send(2, 2'b11, 8'h00);
        idle(5);
        checks++;
        if (obsq.size() != expq.size()) begin failures++; $display("FAIL range_count got=%0d exp=%0d", obsq.size(), expq.size()); end
        while (expq.size() != 0 && obsq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL range_event got=%h exp=%h", o, e); end
        end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_rd_lat2_reset();
        send(2, 2'b10, 8'd5);
        send(2, 2'b11, 8'h00);
        idle(4);
        checks++;
        if (obsq.size() != expq.size()) begin failures++; $display("FAIL lat2_count got=%0d exp=%0d", obsq.size(), expq.size()); end
        while (expq.size() != 0 && obsq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL lat2_event got=%h exp=%h", o, e); end
        end
        expq.delete(); obsq.delete();
        send(2, 2'b11, 8'h00);
        rst_n = 1'b0;
        void'(expq.pop_back());
        model_reset();
        idle(2);
        checks++;
        if (dout[2] !== 8'h00) begin failures++; $display("FAIL lat2_reset_dout got=%h exp=00", dout[2]); end
        rst_n = 1'b1;
        idle(4);
        checks++;
        if (tx[2] !== 1'b0 || dout[2] !== 8'h00) begin failures++; $display("FAIL lat2_after_reset got=%b/%h exp=0/00", tx[2], dout[2]); end
        checks++;
        if (obsq.size() != 0) begin failures++; $display("FAIL lat2_dropped got=%0d exp=0", obsq.size()); end
        expq.delete(); obsq.delete();
    endtask

    task automatic test_independence();
        send(3, 2'b00, 8'd7);
        send(3, 2'b10, 8'd7);
        send(3, 2'b01, 8'h10);
        send(3, 2'b11, 8'h00);
        send(3, 2'b01, 8'h20);
        send(3, 2'b11, 8'h00);
        send(3, 2'b11, 8'h00);
        send(3, 2'b01, 8'h30);
        send(3, 2'b11, 8'h00);
        idle(4);
        checks++;
        if (obsq.size() != expq.size()) begin failures++; $display("FAIL indep_count got=%0d exp=%0d", obsq.size(), expq.size()); end
        while (expq.size() != 0 && obsq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL indep_event got=%h exp=%h", o, e); end
        end
        expq.delete(); obsq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        rxv   = 1'b0;
        din   = '0;
        sel   = 0;
        model_reset();
        idle(3);
        test_reset();
        rst_n = 1'b1;
        idle(2);
        test_defaults();
        test_burst();
        test_wrap();
        test_range();
        test_rd_lat2_reset();
        test_independence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
